inv_shift_rows_seq: RTL and testbench
=====================================

Name: inv_shift_rows_seq

Overview:
- Sequential AES row-permutation engine; primary use is InvShiftRows on the decryption datapath, the inverse of the encryption-side ShiftRows.
- Sits between the inverse-round state register and InvSubBytes.
- Per-transaction direction select (inverse/forward) so one instance can serve either side and the bench can check round-trips.
- Valid/ready on both sides. Optional byte-serial mode rotates one position per cycle to save mux area.

Parameters:
SERIAL, 1, 1 = rotate rows one position per cycle (3 ROT cycles); 0 = full permutation at load (1-cycle latency)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
in_valid  in  1  upstream has a state word
in_ready  out  1  engine accepts in_data this cycle
in_data  in  128  AES state; byte (r,c) at in_data[(15-(r+4c))*8 +: 8]; byte 0 (row 0, col 0) is bits 127:120
in_fwd  in  1  sampled at accept: 0 = InvShiftRows, 1 = forward ShiftRows
out_valid  out  1  out_data holds the result
out_ready  in  1  downstream takes out_data
out_data  out  128  permuted state, same byte mapping as in_data
busy  out  1  high in ROT or HOLD

Behaviour:
- Reset (rst=1 at an edge): state<=IDLE, data register<=0, step counter<=0, dir flag<=0. Outputs after reset: out_valid=0, out_data=0, busy=0, in_ready=1.
- Reset wins over every other event, mid-ROT or mid-HOLD included: the transaction is dropped and no out_valid pulse follows.
- Permutation:
  - Inverse: out[r][c] = in[r][(c-r) mod 4], i.e. row r rotated right by r.
  - Forward: out[r][c] = in[r][(c+r) mod 4].
  - Row 0 is never changed.
- FSM states: IDLE, ROT, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_fwd into the dir flag.
  - SERIAL=1: load in_data raw, counter<=1, go to ROT.
  - SERIAL=0: load the fully permuted word, go to HOLD.
- ROT (SERIAL=1 only):
  - in_ready=0; out_valid=0.
  - At step k (k=1,2,3), every row r>=k rotates by one position: right for inverse, left for forward.
  - After 3 steps, row r has rotated r positions.
  - counter increments each step; after step 3, go to HOLD.
  - The ROT sequence cannot be stalled.
- HOLD:
  - out_valid=1; out_data is stable until the handshake.
  - On out_ready with in_valid=0: go to IDLE.
  - in_ready = out_ready in HOLD (combinational).
  - If out_ready and in_valid are both high at the same edge: the result is delivered and the new word is accepted at that same edge. Next state is ROT (SERIAL=1) or HOLD (SERIAL=0), with no bubble.
- Latency, accept edge to out_valid high:
  - SERIAL=0: 1 cycle; sustained throughput 1 word/cycle.
  - SERIAL=1: 4 cycles (accept, then 3 ROT edges); max throughput 1 word per 4 cycles.
- out_data is driven directly from the data register. Intermediate values are visible during ROT, but only out_valid qualifies them.
- in_data and in_fwd are ignored when not accepted. Changes to in_fwd after accept do not affect the transaction in flight.
- No X propagation: every register is reset.

Test Plan:
- Inverse, SERIAL=1: in_data=000102030405060708090a0b0c0d0e0f, in_fwd=0 -> 4 cycles later out_data=000d0a07_04010e0b_0805020f_0c090603, out_valid=1, busy=1.
- Forward, same input, in_fwd=1 -> out_data=00050a0f_04090e03_080d0207_0c01060b.
- Round-trip: forward result above fed back with in_fwd=0 -> out_data=000102030405060708090a0b0c0d0e0f. Repeat for SERIAL=0 with 1-cycle latency.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD -> out_valid stays 1, out_data stable, in_ready=0. Raise out_ready with in_valid=1 -> same-edge handoff, next result follows 4 cycles later with no idle cycle.
- FIPS-197 InvShiftRows vector: in_data=7ad5fda789ef4e272bca100b3d9ff59f, in_fwd=0 -> out_data=7a9f102789d5f50b2beffd9f3dca4ea7.
- Reset mid-ROT: assert rst one cycle after accept -> next cycle out_valid=0, out_data=0, busy=0, in_ready=1, and no spurious out_valid afterwards.

Source files
------------

// File: rtl/inv_shift_rows_seq.sv
// inv_shift_rows_seq
//   AES row-permutation engine for the decryption datapath. Performs
//   InvShiftRows (row r rotated right by r) or, per transaction, forward
//   ShiftRows (row r rotated left by r). With SERIAL=1 the rows are rotated
//   one position per cycle over three ROT cycles; with SERIAL=0 the full
//   permutation is applied at load.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   upstream has a state word
//   in_ready   engine accepts in_data this cycle
//   in_data    AES state, byte (r,c) at [(15-(r+4c))*8 +: 8]
//   in_fwd     sampled at accept: 0 = InvShiftRows, 1 = ShiftRows
//   out_valid  out_data holds the result
//   out_ready  downstream takes out_data
//   out_data   permuted state, same byte mapping as in_data
//   busy       high in ROT or HOLD
module inv_shift_rows_seq #(
    parameter bit SERIAL = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_fwd,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t       state_q;
    logic [127:0] data_q;
    logic [1:0]   cnt_q;
    logic         dir_q;

    logic         accept;
    logic [127:0] data_full;
    logic [127:0] data_step;

    // Bit offset of byte (r,c) inside the 128-bit state word.
    function automatic int unsigned bidx(input int unsigned r, input int unsigned c);
        return (15 - (r + 4 * c)) * 8;
    endfunction

    // Complete permutation: row r rotated by r (right if inverse, left if forward).
    function automatic logic [127:0] full_perm(input logic [127:0] w, input logic fwd);
        logic [127:0] o;
        int unsigned  src;
        o = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                src = fwd ? ((c + r) % 4) : ((c + 4 - r) % 4);
                o[bidx(r, c) +: 8] = w[bidx(r, src) +: 8];
            end
        end
        return o;
    endfunction

    // One serial step k: every row r >= k rotates by a single position, so
    // after steps 1..3 row r has moved exactly r positions.
    function automatic logic [127:0] row_step(input logic [127:0] w,
                                              input int unsigned k,
                                              input logic fwd);
        logic [127:0] o;
        int unsigned  src;
        o = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                if (r >= k) begin
                    src = fwd ? ((c + 1) % 4) : ((c + 3) % 4);
                end else begin
                    src = c;
                end
                o[bidx(r, c) +: 8] = w[bidx(r, src) +: 8];
            end
        end
        return o;
    endfunction

    // In HOLD a new word may be taken on the same edge the result leaves.
    assign in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign out_data  = data_q;

    assign data_full = full_perm(in_data, in_fwd);
    assign data_step = row_step(data_q, {30'd0, cnt_q}, dir_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, HOLD: begin
                    if (accept) begin
                        dir_q <= in_fwd;
                        if (SERIAL) begin
                            data_q  <= in_data;
                            cnt_q   <= 2'd1;
                            state_q <= ROT;
                        end else begin
                            data_q  <= data_full;
                            state_q <= HOLD;
                        end
                    end else if ((state_q == HOLD) && out_ready) begin
                        state_q <= IDLE;
                    end
                end
                ROT: begin
                    data_q <= data_step;
                    // Counter wraps 3 -> 0 on the last step.
                    cnt_q  <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_q <= HOLD;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_shift_rows_seq.sv
// Testbench for inv_shift_rows_seq. Instance 0 uses SERIAL=1, instance 1
// uses SERIAL=0. Stimulus pushes expected words into per-instance queues;
// a negedge monitor pops and compares whenever a result is handed off.
module tb_inv_shift_rows_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic [127:0] in_data   [2];
    logic         in_fwd    [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic [127:0] out_data  [2];
    logic         busy      [2];

    inv_shift_rows_seq #(.SERIAL(1'b1)) u_ser (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_fwd(in_fwd[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .busy(busy[0])
    );

    inv_shift_rows_seq #(.SERIAL(1'b0)) u_par (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_fwd(in_fwd[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .busy(busy[1])
    );

    int checks = 0;
    int errors = 0;

    logic [127:0] q0[$];
    logic [127:0] q1[$];
    bit           held      [2];
    logic [127:0] held_data [2];
    bit           rnd_bp = 1'b0;

    localparam logic [127:0] V0       = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] V0_INV   = 128'h000d0a0704010e0b0805020f0c090603;
    localparam logic [127:0] V0_FWD   = 128'h00050a0f04090e03080d02070c01060b;
    localparam logic [127:0] FIPS_IN  = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    localparam logic [127:0] FIPS_OUT = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;

    // Reference: view the word as a 4x4 byte matrix, out[r][c] = in[r][c -/+ r].
    function automatic logic [127:0] ref_perm(input logic [127:0] x, input logic fwd);
        logic [7:0]   m [4][4];
        logic [127:0] o;
        int           s;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = x[127 - 8 * (r + 4 * c) -: 8];
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                s = fwd ? (c + r) % 4 : (c - r + 4) % 4;
                o[127 - 8 * (r + 4 * c) -: 8] = m[r][s];
            end
        return o;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int d, input logic [127:0] v);
        if (d == 0) q0.push_back(v);
        else        q1.push_back(v);
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic send(input int d, input logic [127:0] data, input logic fwd,
                        input logic [127:0] exp, output int waits);
        bit ok;
        ok = 1'b0;
        waits = 0;
        in_valid[d] = 1'b1;
        in_data[d]  = data;
        in_fwd[d]   = fwd;
        while (!ok) begin
            @(negedge clk);
            if (in_ready[d]) begin
                ok = 1'b1;
            end else begin
                waits++;
                if (waits > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL accept%0d: in_ready stayed 0 for 200 cycles, expected 1", d);
                    break;
                end
            end
        end
        if (ok) push(d, exp);
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        in_data[d]  = {4{$urandom}};
        in_fwd[d]   = 1'($urandom_range(0, 1));
    endtask

    // Counts negedges after the accept edge until out_valid rises.
    task automatic lat(input int d, input int want);
        int c;
        c = 1;
        forever begin
            @(negedge clk);
            if (out_valid[d] || c > 50) break;
            c++;
        end
        check($sformatf("latency%0d", d), 128'(c), 128'(want));
        check($sformatf("busy_in_hold%0d", d), 128'(busy[d]), 128'(1));
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare on every handoff, and require stable data while stalled.
    always @(negedge clk) begin
        logic [127:0] e;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                held[d] = 1'b0;
            end else if (out_valid[d]) begin
                if (held[d]) check($sformatf("stable%0d", d), out_data[d], held_data[d]);
                if (out_ready[d]) begin
                    held[d] = 1'b0;
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out%0d: got out_valid with %h, expected no output", d, out_data[d]);
                    end else begin
                        if (d == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        check($sformatf("out_data%0d", d), out_data[d], e);
                    end
                end else begin
                    held[d]      = 1'b1;
                    held_data[d] = out_data[d];
                end
            end
        end
    end

    // Random backpressure during the random phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_bp) begin
                for (int d = 0; d < 2; d++) out_ready[d] = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin
        int w;
        int n;
        logic [127:0] rd;
        logic         rf;

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            in_data[d]   = '0;
            in_fwd[d]    = 1'b0;
            out_ready[d] = 1'b1;
            held[d]      = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_out_valid%0d", d), 128'(out_valid[d]), 128'(0));
            check($sformatf("rst_out_data%0d", d), out_data[d], '0);
            check($sformatf("rst_busy%0d", d), 128'(busy[d]), 128'(0));
            check($sformatf("rst_in_ready%0d", d), 128'(in_ready[d]), 128'(1));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vectors, including round-trip and the FIPS-197 vector.
        for (int d = 0; d < 2; d++) begin
            send(d, V0, 1'b0, V0_INV, w);       lat(d, d == 0 ? 4 : 1);
            send(d, V0, 1'b1, V0_FWD, w);       lat(d, d == 0 ? 4 : 1);
            send(d, V0_FWD, 1'b0, V0, w);       lat(d, d == 0 ? 4 : 1);
            send(d, FIPS_IN, 1'b0, FIPS_OUT, w); lat(d, d == 0 ? 4 : 1);
        end

        // Backpressure on the serial instance, then same-edge handoff.
        out_ready[0] = 1'b0;
        rd = {4{$urandom}};
        send(0, rd, 1'b0, ref_perm(rd, 1'b0), w);
        lat(0, 4);
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", 128'(out_valid[0]), 128'(1));
            check("bp_in_ready", 128'(in_ready[0]), 128'(0));
        end
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        rd = {4{$urandom}};
        send(0, rd, 1'b1, ref_perm(rd, 1'b1), w);
        check("handoff_waits", 128'(w), 128'(0));
        lat(0, 4);

        // Sustained 1 word/cycle on the parallel instance.
        for (int i = 0; i < 4; i++) begin
            rd = {4{$urandom}};
            rf = 1'($urandom_range(0, 1));
            send(1, rd, rf, ref_perm(rd, rf), w);
            check("burst_waits", 128'(w), 128'(0));
        end

        // Randomized traffic with random backpressure and idle gaps.
        rnd_bp = 1'b1;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 150; i++) begin
                rd = {4{$urandom}};
                rf = 1'($urandom_range(0, 1));
                send(d, rd, rf, ref_perm(rd, rf), w);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        rnd_bp = 1'b0;
        out_ready[0] = 1'b1;
        out_ready[1] = 1'b1;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("drain_q0", 128'(q0.size()), 128'(0));
        check("drain_q1", 128'(q1.size()), 128'(0));
        @(posedge clk);
        #1;

        // Reset one cycle after accept on the serial instance: result is dropped.
        send(0, V0, 1'b0, V0_INV, w);
        rst = 1'b1;
        q0.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrot_out_valid", 128'(out_valid[0]), 128'(0));
        check("midrot_out_data", out_data[0], '0);
        check("midrot_busy", 128'(busy[0]), 128'(0));
        check("midrot_in_ready", 128'(in_ready[0]), 128'(1));
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid[0]) n++;
        end
        check("midrot_no_spurious", 128'(n), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
